// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the MEM-stage data-memory responder.
//   state_t   - responder FSM states (IDLE, BUSY, RESP)
//   WE_NONE   - byte-enable pattern that marks a load
//   WE_WORD   - byte-enable pattern for a full-word store
//   CNT_W     - width of the wait-state counter (supports 0..15 wait states)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_WORD = 4'b1111;

    localparam int CNT_W = 4;

    // Any access whose byte offset is non-zero is rejected, load or store.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM with per-byte write enables.
//   clk    - rising-edge clock
//   en     - access enable; nothing happens when low
//   we     - byte-lane write enables, WE_NONE performs a read
//   addr   - word address
//   wdata  - store data
//   rdata  - read data, registered, updated only by reads
// Contents are never reset.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == WE_NONE) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the MEM-stage load/store interface. Accepts
// one word request at a time, performs it after WAIT_CYCLES wait states and
// holds the pipeline through mem_stall until the response cycle.
//   clk        - rising-edge clock
//   rst        - asynchronous reset, active low
//   mem_en     - request valid (load or store)
//   mem_we     - byte-lane write enables, 0000 = load
//   mem_addr   - byte address; bits [ADDR_W+1:2] index the RAM, upper bits alias
//   mem_wdata  - store data
//   mem_rdata  - load data, valid in the response cycle and held afterwards
//   mem_stall  - hold request to the hazard unit (mem_en while not responding)
//   addr_err   - one-cycle pulse in the response cycle of a misaligned access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        addr_err
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W+1:0]  addr_q, addr_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               ld_q;

    logic               access;
    logic               misaligned;
    logic [ADDR_W+1:0]  acc_addr;
    logic [3:0]         acc_we;
    logic [31:0]        acc_wdata;
    logic               ram_en;
    logic [31:0]        ram_rdata;
    logic               unused_addr_hi;

    // Address bits above the RAM index alias by design.
    assign unused_addr_hi = ^mem_addr[31:ADDR_W+2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        access    = 1'b0;
        acc_addr  = addr_q;
        acc_we    = we_q;
        acc_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (mem_en) begin
                    addr_d  = mem_addr[ADDR_W+1:0];
                    we_d    = mem_we;
                    wdata_d = mem_wdata;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the access edge is the accept edge,
                        // so the RAM sees the live request instead of the latch.
                        access    = 1'b1;
                        acc_addr  = mem_addr[ADDR_W+1:0];
                        acc_we    = mem_we;
                        acc_wdata = mem_wdata;
                        state_d   = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign misaligned = access & is_misaligned(acc_addr[1:0]);

    // Gating with rst keeps the RAM untouched while reset is held.
    assign ram_en = access & ~misaligned & rst;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (acc_we),
        .addr  (acc_addr[ADDR_W+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= misaligned;
            ld_q    <= access & ~misaligned & (acc_we == WE_NONE);
            // Capture the RAM output during the load's response cycle so it
            // stays on mem_rdata until the next successful load.
            if (ld_q) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    // The RAM output register already holds the load result in RESP.
    assign mem_rdata = ld_q ? ram_rdata : rdata_q;
    assign mem_stall = mem_en & (state_q != RESP);
    assign addr_err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AW  = 10;
    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        en    [2];
    logic [3:0]  we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        stall [2];
    logic        err   [2];

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC0)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .mem_en(en[0]), .mem_we(we[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]),
        .mem_stall(stall[0]), .addr_err(err[0])
    );

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC1)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .mem_en(en[1]), .mem_we(we[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]),
        .mem_stall(stall[1]), .addr_err(err[1])
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word array per instance plus the last loaded value.
    bit [31:0] mdl [2][1024];
    bit [31:0] mrd [2];

    function automatic int wc(input int k);
        return (k == 0) ? WC0 : WC1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply the architectural effect of one request to the model and return
    // what the responder should present in its response cycle.
    function automatic exp_t model_req(input int k, input logic [3:0] w,
                                       input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        idx = int'(a[AW+1:2]);
        if (a[1:0] != 2'b00) begin
            e = {mrd[k], 1'b1};
        end else if (w == 4'b0000) begin
            mrd[k] = mdl[k][idx];
            e = {mrd[k], 1'b0};
        end else begin
            for (int i = 0; i < 4; i++)
                if (w[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
            e = {mrd[k], 1'b0};
        end
        return e;
    endfunction

    // Monitor: every cycle in which a request is up but not stalled is a
    // response, and is checked against the oldest expectation.
    task automatic mon(input int k);
        exp_t e;
        if (rst_n[k] && en[k]) begin
            if (!stall[k]) begin
                if ((k == 0 && sbq0.size() == 0) || (k == 1 && sbq1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp%0d: response with empty scoreboard (t=%0t)", k, $time);
                end else begin
                    e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check($sformatf("rdata%0d", k), rdata[k], e.rd);
                    check($sformatf("addr_err%0d", k), {31'd0, err[k]}, {31'd0, e.er});
                end
            end else begin
                check($sformatf("err_quiet%0d", k), {31'd0, err[k]}, 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // One complete request; entered and left at posedge+1.
    task automatic req(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   sc;
        bit   done;
        e = model_req(k, w, a, d);
        if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
        en[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        sc = 0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall[k]) begin
                done = 1'b1;
                break;
            end
            sc++;
            @(posedge clk);
            #1;
            // Request inputs wander while the access is outstanding.
            we[k] = 4'($urandom); addr[k] = $urandom; wdata[k] = $urandom;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_timeout%0d: stall never dropped (t=%0t)", k, $time);
        end
        check($sformatf("stall_len%0d", k), sc, wc(k) + 1);
        @(posedge clk);
        #1;
        en[k] = 1'b0;
    endtask

    // Request withdrawn one cycle after issue; the access must still land.
    task automatic flush_req(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = model_req(k, w, a, d);
        en[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        #1;
        en[k] = 1'b0;
        addr[k] = $urandom; wdata[k] = $urandom;
        #1;
        check($sformatf("flush_stall%0d", k), {31'd0, stall[k]}, 32'd0);
        repeat (wc(k) + 2) @(posedge clk);
        #1;
    endtask

    // Store abandoned by reset while BUSY: must leave RAM untouched.
    task automatic reset_req(input int k, input logic [31:0] a, input logic [31:0] d);
        en[k] = 1'b1; we[k] = WE_WORD; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        #3;
        rst_n[k] = 1'b0;
        en[k] = 1'b0;
        #1;
        mrd[k] = '0;
        check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
        check($sformatf("rst_err%0d", k), {31'd0, err[k]}, 32'd0);
        check($sformatf("rst_stall%0d", k), {31'd0, stall[k]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n[k] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int k, input int n, input int pool[$]);
        logic [31:0] a;
        logic [3:0]  w;
        int          r;
        for (int t = 0; t < n; t++) begin
            a = $urandom;
            a[AW+1:2] = AW'(pool[$urandom_range(pool.size() - 1)]);
            if ($urandom_range(7) != 0) a[1:0] = 2'b00;
            w = ($urandom_range(1) == 0) ? WE_NONE : 4'($urandom_range(15, 1));
            r = $urandom_range(9);
            if (r == 0) flush_req(k, w, a, $urandom);
            else        req(k, w, a, $urandom);
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pool0[$];
        int pool1[$];
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; en[k] = 1'b0; we[k] = '0; addr[k] = '0; wdata[k] = '0;
            mrd[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("init_rdata%0d", k), rdata[k], 32'd0);
            check($sformatf("init_err%0d", k), {31'd0, err[k]}, 32'd0);
            check($sformatf("init_stall%0d", k), {31'd0, stall[k]}, 32'd0);
            rst_n[k] = 1'b1;
        end
        @(posedge clk);
        #1;

        // Instance with two wait states.
        req(0, WE_WORD, 32'h40, 32'hDEADBEEF);
        req(0, WE_NONE, 32'h40, 32'h0);
        req(0, WE_WORD, 32'h44, 32'h11223344);
        req(0, 4'b0010, 32'h44, 32'h0000AA00);
        req(0, WE_NONE, 32'h44, 32'h0);
        check("byte_store_model", mrd[0], 32'h1122AA44);
        req(0, WE_WORD, 32'h42, 32'hFFFFFFFF);
        req(0, WE_NONE, 32'h40, 32'h0);
        flush_req(0, WE_WORD, 32'h80, 32'h12345678);
        req(0, WE_NONE, 32'h80, 32'h0);
        req(0, WE_WORD, 32'h84, 32'hCAFEF00D);
        reset_req(0, 32'h84, 32'h55555555);
        req(0, WE_NONE, 32'h84, 32'h0);
        req(0, WE_WORD, 32'h1000, 32'hA5A5A5A5);
        req(0, WE_NONE, 32'h0, 32'h0);
        req(0, WE_NONE, 32'h43, 32'h0);
        pool0 = '{0, 16, 17, 32, 33};
        random_phase(0, 60, pool0);

        // Instance with no wait states.
        for (int i = 0; i < 4; i++) req(1, WE_WORD, 32'(i * 4), $urandom);
        req(1, WE_WORD, 32'h0, 32'h0BADCAFE);
        req(1, WE_NONE, 32'h0, 32'h0);
        req(1, 4'b1001, 32'h1004, 32'h77000066);
        req(1, WE_NONE, 32'h4, 32'h0);
        pool1 = '{0, 1, 2, 3};
        random_phase(1, 40, pool1);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty0", sbq0.size(), 0);
        check("sb_empty1", sbq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
